health_controller: RTL and testbench
====================================

Name: health_controller

Overview:
- Central HP controller for one player in the boss-fight game loop.
- Accepts damage and heal requests from several gameplay sources (boss contact, boss projectile, heart pickup, ...) and arbitrates them round-robin, one per clock.
- Applies a frame-tick-based invulnerability cooldown and tracks death.
- Drives current_health into the HUD heart renderer and the game-state logic.

Parameters:
- MAX_HP, 10: health ceiling; must be ≤ 15.
- N_REQ, 3: number of request sources; ≥ 2.
- COOLDOWN_TICKS, 60: invulnerability length after damage, in frame_tick units; ≤ 255.
- FLASH_TICKS, 8: hit_flash length, in frame_tick units; ≤ COOLDOWN_TICKS.
- REGEN_TICKS, 300: regeneration period, in frame_tick units; used only with HP_REGEN_EN.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- game_start  in  1  one-cycle pulse; (re)initialises the player.
- game_active  in  2  game-state code; value 1 = fight in progress.
- frame_tick  in  1  one-cycle pulse per video frame.
- init_hp  in  4  starting HP, sampled on game_start.
- req_valid  in  N_REQ  per-source request valid.
- req_heal  in  N_REQ  per-source kind: 1 = heal, 0 = damage.
- req_amt  in  3*N_REQ  per-source amount; source i occupies bits [3i+2:3i].
- req_ready  out  N_REQ  one-hot grant.
- current_health  out  4  present HP.
- invuln  out  1  high while cooldown is running.
- hit_flash  out  1  high for FLASH_TICKS frames after a hit.
- dead  out  1  high in DEAD state.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state IDLE, current_health 0, all counters 0.
  - req_ready 0, invuln 0, hit_flash 0, dead 0.
  - round-robin pointer at 0.
- FSM states: IDLE, ALIVE, INVULN, DEAD.
- game_start has top priority in every state, including mid-cooldown and DEAD. On the next edge:
  - current_health = min(init_hp, MAX_HP).
  - Counters cleared, state ALIVE.
  - No request is granted that cycle.
  - If init_hp == 0, state goes directly to DEAD.
- Frozen condition: while game_active != 1, req_ready = 0 and all counters hold their values. State is retained, so pause and resume is seamless.
- Arbitration:
  - req_ready is combinational.
  - Exactly one bit is set, for the first valid source at or after pointer, scanning round-robin.
  - Grant is given only when the state is ALIVE or INVULN, the frozen condition does not apply, and game_start is low.
  - Handshake completes on valid && ready.
  - Pointer moves to grant index + 1 (wrapping at N_REQ) after each handshake.
  - A source holds valid until it is acked.
- Effect of a handshake, registered; current_health changes on the edge ending the handshake cycle (1-cycle latency):
  - Heal: current_health = min(current_health + amt, MAX_HP). Use a 5-bit intermediate sum. Accepted in ALIVE and INVULN.
  - Damage in ALIVE: current_health = max(current_health − amt, 0), computed with borrow check (no wrap).
    - Result 0 → DEAD.
    - Otherwise → INVULN, cooldown = COOLDOWN_TICKS, flash = FLASH_TICKS.
  - Damage in INVULN: acked and discarded, with no effect. Sources therefore cannot queue hits.
  - amt == 0: acked, no state change, no invulnerability.
- Counters:
  - cooldown and flash decrement on frame_tick while the game is active.
  - INVULN → ALIVE on the frame_tick that takes cooldown from 1 to 0.
  - invuln = (state == INVULN); hit_flash = (flash != 0).
- DEAD:
  - req_ready = 0, dead = 1, current_health = 0.
  - Exited only by game_start or reset.
- Simultaneous requests resolve purely by arbitration; one effect per cycle.

Optional Feature:
- HP_REGEN_EN:
  - Defined: a regen counter counts frame_ticks in ALIVE only and clears on any damage handshake. On reaching REGEN_TICKS, current_health increments by 1 (saturating at MAX_HP) and the counter clears. Regeneration has lower priority than a handshake in the same cycle; it is deferred by one cycle.
  - Undefined: no regen counter or logic is generated; HP changes only through requests and game_start.

Decomposition:
- Package hp_pkg:
  - hp_state_t enum {IDLE, ALIVE, INVULN, DEAD}.
  - HP_W = 4, AMT_W = 3, GAME_ACTIVE_FIGHT = 2'd1.
- Sub-module rr_arbiter (parameter N):
  - Inputs req[N], ptr, enable.
  - Outputs one-hot gnt and gnt_idx.
  - Purely combinational; the pointer register stays in health_controller.

Test Plan:
- Reset, then game_start with init_hp = 12 → current_health = 10; after 1 cycle state ALIVE, dead = 0.
- game_active = 1; src0 damage amt = 3 → ack in same cycle; next cycle HP = 7, invuln = 1, hit_flash = 1. hit_flash clears after 8 frame_ticks; invuln clears after 60 frame_ticks.
- During INVULN, src1 damage amt = 2 → acked, HP remains 7. Heal amt = 5 from src2 → HP = 10 (saturated, not 12).
- All three sources valid simultaneously in ALIVE → grants in order 0, 1, 2 on successive handshakes; pointer wraps back to 0.
- HP = 2, damage amt = 7 → HP = 0, dead = 1, req_ready stays 0. game_start with init_hp = 5 → HP = 5, ALIVE.
- game_active = 2 during INVULN with 10 frame_ticks → cooldown unchanged, no acks. With HP_REGEN_EN, 300 frame_ticks in ALIVE at HP = 4 → HP = 5.

Source files
------------

// File: rtl/hp_pkg.sv
// rtl/hp_pkg.sv - shared types and widths for the player health controller
package hp_pkg;
  localparam int HP_W = 4;
  localparam int AMT_W = 3;
  localparam logic [1:0] GAME_ACTIVE_FIGHT = 2'd1;

  typedef enum logic [1:0] {IDLE, ALIVE, INVULN, DEAD} hp_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter; grants the first request at or after ptr
module rr_arbiter #(
  parameter int N = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             enable,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);
  int   idx;
  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (enable && !found && req[IDX_W'(idx)]) begin
        gnt[IDX_W'(idx)] = 1'b1;
        gnt_idx          = IDX_W'(idx);
        found            = 1'b1;
      end
    end
  end
endmodule

// File: rtl/health_controller.sv
// rtl/health_controller.sv - player HP controller with round-robin heal/damage requests
// and frame-tick invulnerability; define HP_REGEN_EN for passive regeneration.
module health_controller
  import hp_pkg::*;
#(
  parameter int MAX_HP         = 10,
  parameter int N_REQ          = 3,
  parameter int COOLDOWN_TICKS = 60,
  parameter int FLASH_TICKS    = 8,
  parameter int REGEN_TICKS    = 300
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               game_start,
  input  logic [1:0]         game_active,
  input  logic               frame_tick,
  input  logic [HP_W-1:0]    init_hp,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ-1:0]   req_heal,
  input  logic [3*N_REQ-1:0] req_amt,
  output logic [N_REQ-1:0]   req_ready,
  output logic [HP_W-1:0]    current_health,
  output logic               invuln,
  output logic               hit_flash,
  output logic               dead
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [HP_W-1:0] MAX_HP_V = HP_W'(MAX_HP);

  hp_state_t        state;
  logic [HP_W-1:0]  hp;
  logic [7:0]       cooldown;
  logic [7:0]       flash;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_next;
  logic [PTR_W-1:0] gnt_idx;
  logic [N_REQ-1:0] gnt;
  logic             fight;
  logic             arb_en;
  logic             handshake;
  logic             sel_heal;
  logic [AMT_W-1:0] sel_amt;
  logic [HP_W-1:0]  amt_ext;
  logic [HP_W:0]    heal_sum;
  logic [HP_W-1:0]  heal_hp;
  logic [HP_W-1:0]  dmg_hp;
  logic [HP_W-1:0]  start_hp;

  assign fight  = (game_active == GAME_ACTIVE_FIGHT);
  assign arb_en = fight && !game_start && (state == ALIVE || state == INVULN);

  rr_arbiter #(.N(N_REQ), .IDX_W(PTR_W)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .enable  (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign handshake = |gnt;
  assign sel_heal  = req_heal[gnt_idx];
  assign sel_amt   = req_amt[AMT_W*int'(gnt_idx) +: AMT_W];
  assign amt_ext   = {{(HP_W-AMT_W){1'b0}}, sel_amt};
  assign ptr_next  = (gnt_idx == PTR_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;

  // Saturating arithmetic: heal uses one extra bit, damage clamps at zero instead of wrapping.
  assign heal_sum = {1'b0, hp} + {1'b0, amt_ext};
  assign heal_hp  = (heal_sum > {1'b0, MAX_HP_V}) ? MAX_HP_V : heal_sum[HP_W-1:0];
  assign dmg_hp   = (amt_ext > hp) ? '0 : hp - amt_ext;
  assign start_hp = (init_hp > MAX_HP_V) ? MAX_HP_V : init_hp;

`ifdef HP_REGEN_EN
  localparam int REGEN_W = $clog2(REGEN_TICKS + 1);
  logic [REGEN_W-1:0] regen;
  logic               regen_due;

  // A handshake in the same cycle wins; the pending regen fires on the next free cycle.
  assign regen_due = fight && (state == ALIVE) && (regen == REGEN_W'(REGEN_TICKS)) && !handshake;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hp       <= '0;
      cooldown <= '0;
      flash    <= '0;
      ptr      <= '0;
`ifdef HP_REGEN_EN
      regen    <= '0;
`endif
    end else if (game_start) begin
      hp       <= start_hp;
      cooldown <= '0;
      flash    <= '0;
      state    <= (init_hp == '0) ? DEAD : ALIVE;
`ifdef HP_REGEN_EN
      regen    <= '0;
`endif
    end else if (fight) begin
      if (frame_tick && flash != '0) flash <= flash - 8'd1;
      if (frame_tick && state == INVULN && cooldown != '0) begin
        cooldown <= cooldown - 8'd1;
        if (cooldown == 8'd1) state <= ALIVE;
      end
`ifdef HP_REGEN_EN
      if (frame_tick && state == ALIVE && regen != REGEN_W'(REGEN_TICKS)) regen <= regen + 1'b1;
      if (regen_due) begin
        hp    <= (hp == MAX_HP_V) ? hp : hp + 1'b1;
        regen <= '0;
      end
`endif
      if (handshake) begin
        ptr <= ptr_next;
        if (sel_heal) begin
          hp <= heal_hp;
        end else if (sel_amt != '0 && state == ALIVE) begin
          hp <= dmg_hp;
          if (dmg_hp == '0) begin
            state <= DEAD;
          end else begin
            state    <= INVULN;
            cooldown <= 8'(COOLDOWN_TICKS);
            flash    <= 8'(FLASH_TICKS);
          end
        end
`ifdef HP_REGEN_EN
        if (!sel_heal) regen <= '0;
`endif
      end
    end
  end

  assign current_health = hp;
  assign invuln         = (state == INVULN);
  assign hit_flash      = (flash != '0);
  assign dead           = (state == DEAD);
endmodule

// File: tb/tb_health_controller.sv
// tb/tb_health_controller.sv - self-checking bench for health_controller (scoreboarded grants and HP)
module tb_health_controller;
  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       game_start;
  logic [1:0] game_active;
  logic       frame_tick;
  logic [3:0] init_hp;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_heal;
  logic [3*N-1:0] req_amt;
  logic [N-1:0]   req_ready;
  logic [3:0] current_health;
  logic       invuln;
  logic       hit_flash;
  logic       dead;

  always #5 clk = ~clk;

  health_controller #(
    .MAX_HP(10), .N_REQ(N), .COOLDOWN_TICKS(60), .FLASH_TICKS(8), .REGEN_TICKS(300)
  ) dut (
    .clk(clk), .rst_n(rst_n), .game_start(game_start), .game_active(game_active),
    .frame_tick(frame_tick), .init_hp(init_hp), .req_valid(req_valid), .req_heal(req_heal),
    .req_amt(req_amt), .req_ready(req_ready), .current_health(current_health),
    .invuln(invuln), .hit_flash(hit_flash), .dead(dead)
  );

  typedef struct {
    int         gnt;
    logic [3:0] hp;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_hp;
  int   g;
  logic [3:0] h;
  bit   ok;

  task automatic send(input int src, input logic heal, input logic [2:0] amt,
                      output int gidx, output logic [3:0] hp_after);
    bit done;
    done     = 1'b0;
    gidx     = -1;
    hp_after = 'x;
    @(negedge clk);
    req_valid[src]     = 1'b1;
    req_heal[src]      = heal;
    req_amt[3*src +: 3] = amt;
    for (int c = 0; c < 20 && !done; c++) begin
      #1;
      if (req_ready != '0) begin
        for (int i = 0; i < N; i++) if (req_ready[i]) gidx = i;
        done = 1'b1;
      end
      @(negedge clk);
    end
    req_valid[src] = 1'b0;
    if (done) hp_after = current_health;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
    end
  endtask

  task automatic pulse_start(input logic [3:0] hp0);
    @(negedge clk);
    game_start = 1'b1;
    init_hp    = hp0;
    @(negedge clk);
    game_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; game_start = 1'b0; game_active = 2'd1; frame_tick = 1'b0;
    init_hp = '0; req_valid = 3'b111; req_heal = '0; req_amt = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (current_health !== 4'd0) begin n_err++; $display("FAIL reset_hp: got %0d expected 0", current_health); end
    n_cmp++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL reset_ready: got %b expected 000", req_ready); end
    n_cmp++; if ({invuln, hit_flash, dead} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b expected 000", {invuln, hit_flash, dead}); end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL idle_ready: got %b expected 000", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_start();
    pulse_start(4'd12);
    m_hp = 10;
    n_cmp++; if (current_health !== 4'(m_hp)) begin n_err++; $display("FAIL start_hp: got %0d expected %0d", current_health, m_hp); end
    n_cmp++; if ({invuln, dead} !== 2'b00) begin n_err++; $display("FAIL start_flags: got %b expected 00", {invuln, dead}); end
  endtask

  task automatic test_damage();
    exp_q.push_back('{0, 4'((m_hp > 3) ? m_hp - 3 : 0)});
    m_hp = (m_hp > 3) ? m_hp - 3 : 0;
    send(0, 1'b0, 3'd3, g, h);
    e = exp_q.pop_front();
    n_cmp++; if (g !== e.gnt) begin n_err++; $display("FAIL dmg_gnt: got %0d expected %0d", g, e.gnt); end
    n_cmp++; if (h !== e.hp) begin n_err++; $display("FAIL dmg_hp: got %0d expected %0d", h, e.hp); end
    n_cmp++; if ({invuln, hit_flash} !== 2'b11) begin n_err++; $display("FAIL dmg_flags: got %b expected 11", {invuln, hit_flash}); end
    tick(7);
    n_cmp++; if (hit_flash !== 1'b1) begin n_err++; $display("FAIL flash_7: got %b expected 1", hit_flash); end
    tick(1);
    n_cmp++; if ({invuln, hit_flash} !== 2'b10) begin n_err++; $display("FAIL flash_8: got %b expected 10", {invuln, hit_flash}); end
  endtask

  task automatic test_invuln_requests();
    exp_q.push_back('{1, 4'(m_hp)});
    send(1, 1'b0, 3'd2, g, h);
    e = exp_q.pop_front();
    n_cmp++; if (g !== e.gnt) begin n_err++; $display("FAIL inv_dmg_gnt: got %0d expected %0d", g, e.gnt); end
    n_cmp++; if (h !== e.hp) begin n_err++; $display("FAIL inv_dmg_hp: got %0d expected %0d", h, e.hp); end
    m_hp = (m_hp + 5 > 10) ? 10 : m_hp + 5;
    exp_q.push_back('{2, 4'(m_hp)});
    send(2, 1'b1, 3'd5, g, h);
    e = exp_q.pop_front();
    n_cmp++; if (g !== e.gnt) begin n_err++; $display("FAIL heal_gnt: got %0d expected %0d", g, e.gnt); end
    n_cmp++; if (h !== e.hp) begin n_err++; $display("FAIL heal_hp: got %0d expected %0d", h, e.hp); end
  endtask

  task automatic test_frozen();
    game_active = 2'd2;
    @(negedge clk);
    req_valid[0] = 1'b1; req_heal[0] = 1'b0; req_amt[2:0] = 3'd1;
    ok = 1'b1;
    repeat (3) begin
      #1;
      if (req_ready !== 3'b000) ok = 1'b0;
      @(negedge clk);
    end
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL frozen_ready: got grant expected none"); end
    tick(10);
    req_valid = '0;
    game_active = 2'd1;
    tick(51);
    n_cmp++; if (invuln !== 1'b1) begin n_err++; $display("FAIL cool_59: got %b expected 1", invuln); end
    tick(1);
    n_cmp++; if (invuln !== 1'b0) begin n_err++; $display("FAIL cool_60: got %b expected 0", invuln); end
    n_cmp++; if (current_health !== 4'(m_hp)) begin n_err++; $display("FAIL frozen_hp: got %0d expected %0d", current_health, m_hp); end
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 4; k++) exp_q.push_back('{k % 3, 4'(m_hp)});
    @(negedge clk);
    req_heal = '0; req_amt = '0; req_valid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      #1;
      g = -1;
      for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
      e = exp_q.pop_front();
      n_cmp++; if (g !== e.gnt) begin n_err++; $display("FAIL rr_gnt%0d: got %0d expected %0d", k, g, e.gnt); end
      @(negedge clk);
      if (g >= 0) req_valid[g] = 1'b0;
      n_cmp++; if (current_health !== e.hp) begin n_err++; $display("FAIL rr_hp%0d: got %0d expected %0d", k, current_health, e.hp); end
      if (k == 2) req_valid = 3'b111;
    end
    req_valid = '0;
    n_cmp++; if (invuln !== 1'b0) begin n_err++; $display("FAIL rr_amt0_invuln: got %b expected 0", invuln); end
  endtask

  task automatic test_death();
    pulse_start(4'd2);
    m_hp = 2;
    n_cmp++; if (current_health !== 4'd2) begin n_err++; $display("FAIL death_start: got %0d expected 2", current_health); end
    exp_q.push_back('{1, 4'd0});
    send(1, 1'b0, 3'd7, g, h);
    e = exp_q.pop_front();
    n_cmp++; if (g !== e.gnt) begin n_err++; $display("FAIL death_gnt: got %0d expected %0d", g, e.gnt); end
    n_cmp++; if (h !== e.hp) begin n_err++; $display("FAIL death_hp: got %0d expected %0d", h, e.hp); end
    n_cmp++; if (dead !== 1'b1) begin n_err++; $display("FAIL death_flag: got %b expected 1", dead); end
    @(negedge clk);
    req_valid = 3'b111; req_heal = 3'b111; req_amt = {3{3'd4}};
    ok = 1'b1;
    repeat (4) begin
      #1;
      if (req_ready !== 3'b000) ok = 1'b0;
      @(negedge clk);
    end
    req_valid = '0; req_heal = '0; req_amt = '0;
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL dead_ready: got grant expected none"); end
    n_cmp++; if (current_health !== 4'd0) begin n_err++; $display("FAIL dead_hp: got %0d expected 0", current_health); end
    pulse_start(4'd5);
    n_cmp++; if ({current_health, dead, invuln} !== {4'd5, 2'b00}) begin n_err++; $display("FAIL revive: got hp %0d dead %b expected hp 5 dead 0", current_health, dead); end
  endtask

  task automatic test_init_bounds();
    pulse_start(4'd0);
    n_cmp++; if ({current_health, dead} !== {4'd0, 1'b1}) begin n_err++; $display("FAIL init0: got hp %0d dead %b expected hp 0 dead 1", current_health, dead); end
    pulse_start(4'd15);
    n_cmp++; if ({current_health, dead} !== {4'd10, 1'b0}) begin n_err++; $display("FAIL init15: got hp %0d dead %b expected hp 10 dead 0", current_health, dead); end
  endtask

  task automatic test_start_priority();
    m_hp = 10;
    g = -1;
    for (int i = 0; i < 2; i++) begin
      send(2 - i, 1'b0, 3'd4, g, h);
      if (g >= 0) i = 2;
    end
    n_cmp++; if ({h, invuln} !== {4'd6, 1'b1}) begin n_err++; $display("FAIL prio_hit: got hp %0d invuln %b expected hp 6 invuln 1", h, invuln); end
    @(negedge clk);
    game_start = 1'b1; init_hp = 4'd3;
    req_valid[0] = 1'b1; req_heal[0] = 1'b0; req_amt[2:0] = 3'd1;
    #1;
    n_cmp++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL prio_ready: got %b expected 000", req_ready); end
    @(negedge clk);
    game_start = 1'b0; req_valid = '0;
    n_cmp++; if ({current_health, invuln, hit_flash} !== {4'd3, 2'b00}) begin n_err++; $display("FAIL prio_restart: got hp %0d inv %b flash %b expected hp 3 inv 0 flash 0", current_health, invuln, hit_flash); end
  endtask

  task automatic test_regen();
    logic [3:0] want;
    pulse_start(4'd4);
`ifdef HP_REGEN_EN
    want = 4'd5;
`else
    want = 4'd4;
`endif
    tick(300);
    @(negedge clk);
    n_cmp++; if (current_health !== want) begin n_err++; $display("FAIL regen_hp: got %0d expected %0d", current_health, want); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_start();
    test_damage();
    test_invuln_requests();
    test_frozen();
    test_round_robin();
    test_death();
    test_init_bounds();
    test_start_priority();
    test_regen();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
